// File: rtl/hub75_row_monitor_pkg.sv
// Shared HUB75 display types: colour indices and the sampled pin bundle.
package led_display_package;

   localparam int HUB75_COLOURS = 3;
   localparam int HUB75_LANES   = 2;
   localparam int HUB75_ADDR_W  = 4;

   typedef enum logic [1:0] {
      BLUE  = 2'd0,
      GREEN = 2'd1,
      RED   = 2'd2
   } colour_e;

   typedef struct packed {
      logic                                  bclk;
      logic                                  le;
      logic                                  oe_n;
      logic [HUB75_ADDR_W-1:0]               addr;
      logic [HUB75_COLOURS*HUB75_LANES-1:0]  rgb;
   } hub75_pins_t;

endpackage

// File: rtl/hub75_row_monitor_if.sv
// Rebuilt-row delivery channel: one-deep buffer with valid/ready.
interface hub75_row_monitor_if
   import led_display_package::*;
#(
   parameter int NUM_COLS   = 64,
   parameter int NUM_LANES  = 2,
   parameter int ADDR_WIDTH = 4
);
   logic                                      row_valid;
   logic                                      row_ready;
   logic [HUB75_COLOURS*NUM_LANES*NUM_COLS-1:0] row_data;
   logic [ADDR_WIDTH-1:0]                     row_addr;

   modport master (
      output row_valid, row_data, row_addr,
      input  row_ready
   );

   modport slave (
      input  row_valid, row_data, row_addr,
      output row_ready
   );
endinterface

// File: rtl/hub75_row_monitor_sampler.sv
// Two-stage register of the HUB75 pins with rising-edge strobes.
module hub75_pin_sampler
   import led_display_package::*;
#(
   parameter type pins_t = hub75_pins_t
) (
   input  logic  clk,
   input  logic  n_reset,
   input  pins_t pins_i,
   output pins_t pins_o,
   output logic  bclk_rise_o,
   output logic  le_rise_o,
   output logic  oe_rise_o
);

   pins_t a_q;
   pins_t b_q;
   logic  unused_b;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         a_q      <= '0;
         a_q.oe_n <= 1'b1;
         b_q      <= '0;
         b_q.oe_n <= 1'b1;
      end else begin
         a_q <= pins_i;
         b_q <= a_q;
      end
   end

   assign pins_o      = a_q;
   assign bclk_rise_o = a_q.bclk & ~b_q.bclk;
   assign le_rise_o   = a_q.le & ~b_q.le;
   assign oe_rise_o   = a_q.oe_n & ~b_q.oe_n;
   assign unused_b    = ^{b_q.addr, b_q.rgb};

endmodule

// File: rtl/hub75_row_monitor.sv
// HUB75 bus monitor: rebuilds shifted rows, checks length, times OE.
module hub75_row_monitor
   import led_display_package::*;
#(
   parameter int NUM_COLS   = 64,
   parameter int NUM_LANES  = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int OE_CNT_W   = 16
) (
   input  logic                               clk,
   input  logic                               n_reset,
   input  logic                               bclk,
   input  logic [HUB75_COLOURS*NUM_LANES-1:0] rgb,
   input  logic [ADDR_WIDTH-1:0]              addr,
   input  logic                               oe_n,
   input  logic                               le,
   hub75_row_monitor_if.master                row_if,
   output logic                               row_len_err,
   output logic                               overflow,
   output logic [OE_CNT_W-1:0]                oe_cycles,
   output logic                               oe_valid
);

   localparam int PLANES = HUB75_COLOURS * NUM_LANES;
   localparam int ROW_W  = PLANES * NUM_COLS;
   localparam int CNT_W  = $clog2(NUM_COLS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_COLS + 1);

   typedef struct packed {
      logic                  bclk;
      logic                  le;
      logic                  oe_n;
      logic [ADDR_WIDTH-1:0] addr;
      logic [PLANES-1:0]     rgb;
   } pins_t;

   pins_t pins;
   pins_t pins_a;
   logic  bclk_rise, le_rise, oe_rise;
   logic  unused_a;

   assign pins = '{bclk: bclk, le: le, oe_n: oe_n, addr: addr, rgb: rgb};
   assign unused_a = pins_a.bclk ^ pins_a.le;

   hub75_pin_sampler #(
      .pins_t(pins_t)
   ) u_sampler (
      .clk        (clk),
      .n_reset    (n_reset),
      .pins_i     (pins),
      .pins_o     (pins_a),
      .bclk_rise_o(bclk_rise),
      .le_rise_o  (le_rise),
      .oe_rise_o  (oe_rise)
   );

   logic [ROW_W-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] le_addr_q, le_addr_d;
   logic                  valid_q, valid_d;
   logic [ROW_W-1:0]      data_q, data_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  len_err_q, ovf_q, ovf_d;
   logic [OE_CNT_W-1:0]   oe_cnt_q, oe_cnt_d;
   logic [OE_CNT_W-1:0]   oe_hold_q, oe_hold_d;
   logic [OE_CNT_W-1:0]   oe_cyc_q, oe_cyc_d;
   logic                  oe_evt_q, oe_evt_d;
   logic                  oe_valid_q;

   // Shift happens before the LE check so a coincident 64th edge counts.
   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      le_addr_d = le_addr_q;
      if (bclk_rise) begin
         for (int p = 0; p < PLANES; p++) begin
            shift_d[p*NUM_COLS +: NUM_COLS] =
               {shift_q[p*NUM_COLS +: NUM_COLS-1], pins_a.rgb[p]};
         end
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      if (le_rise) begin
         done_d    = (cnt_d == CNT_FULL);
         err_d     = (cnt_d != CNT_FULL);
         le_addr_d = pins_a.addr;
         cnt_d     = '0;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      raddr_d = raddr_q;
      ovf_d   = 1'b0;
      if (valid_q && row_if.row_ready) valid_d = 1'b0;
      if (done_q) begin
         if (!valid_q || row_if.row_ready) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            raddr_d = le_addr_q;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_comb begin
      oe_cnt_d  = oe_cnt_q;
      oe_hold_d = oe_hold_q;
      oe_evt_d  = 1'b0;
      oe_cyc_d  = oe_cyc_q;
      if (!pins_a.oe_n && oe_cnt_q != '1) oe_cnt_d = oe_cnt_q + OE_CNT_W'(1);
      if (oe_rise) begin
         oe_hold_d = oe_cnt_q;
         oe_evt_d  = 1'b1;
         oe_cnt_d  = '0;
      end
      if (oe_evt_q) oe_cyc_d = oe_hold_q;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         le_addr_q  <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         raddr_q    <= '0;
         len_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
         oe_cnt_q   <= '0;
         oe_hold_q  <= '0;
         oe_cyc_q   <= '0;
         oe_evt_q   <= 1'b0;
         oe_valid_q <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         le_addr_q  <= le_addr_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         raddr_q    <= raddr_d;
         len_err_q  <= err_q;
         ovf_q      <= ovf_d;
         oe_cnt_q   <= oe_cnt_d;
         oe_hold_q  <= oe_hold_d;
         oe_cyc_q   <= oe_cyc_d;
         oe_evt_q   <= oe_evt_d;
         oe_valid_q <= oe_evt_q;
      end
   end

   assign row_if.row_valid = valid_q;
   assign row_if.row_data  = data_q;
   assign row_if.row_addr  = raddr_q;
   assign row_len_err      = len_err_q;
   assign overflow         = ovf_q;
   assign oe_cycles        = oe_cyc_q;
   assign oe_valid         = oe_valid_q;

endmodule

// File: tb/tb_hub75_row_monitor.sv
// Directed and random HUB75 traffic against a bit-history row model.
module tb_hub75_row_monitor;
   import led_display_package::*;

   localparam int COLS = 64;
   localparam int PL   = 6;
   localparam int RW   = PL * COLS;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        bclk = 1'b0;
   logic        oe_n = 1'b1;
   logic        le = 1'b0;
   logic [5:0]  rgb = '0;
   logic [3:0]  addr = '0;
   logic        row_len_err, overflow, oe_valid;
   logic [15:0] oe_cycles;

   hub75_row_monitor_if #(
      .NUM_COLS(COLS), .NUM_LANES(2), .ADDR_WIDTH(4)
   ) row_if ();

   hub75_row_monitor #(
      .NUM_COLS(COLS), .NUM_LANES(2), .ADDR_WIDTH(4), .OE_CNT_W(16)
   ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .bclk       (bclk),
      .rgb        (rgb),
      .addr       (addr),
      .oe_n       (oe_n),
      .le         (le),
      .row_if     (row_if),
      .row_len_err(row_len_err),
      .overflow   (overflow),
      .oe_cycles  (oe_cycles),
      .oe_valid   (oe_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    a;
      logic [RW-1:0] d;
   } row_t;

   int         checks = 0;
   int         errors = 0;
   row_t       exp_q[$];
   logic [5:0] bits_q[$];
   row_t       mon_e;
   int         err_seen = 0, ovf_seen = 0, oe_seen = 0;
   int         exp_err = 0, exp_ovf = 0, exp_oe = 0;
   logic [15:0] oe_last = '0;

   task automatic chk(input string tag, input logic [RW-1:0] obs,
                      input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (n_reset) begin
         if (row_if.row_valid && row_if.row_ready) begin
            chk("row_expected", RW'(exp_q.size() != 0), RW'(1));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("row_addr", RW'(row_if.row_addr), RW'(mon_e.a));
               chk("row_data", row_if.row_data, mon_e.d);
            end
         end
         if (row_len_err) err_seen++;
         if (overflow) ovf_seen++;
         if (oe_valid) begin
            oe_seen++;
            oe_last = oe_cycles;
         end
      end
   end

   // Row rule: exactly COLS shifts, first-shifted bit lands at the MSB.
   function automatic void model_latch(input logic [3:0] a, input bit drop);
      row_t r;
      if (bits_q.size() == COLS) begin
         r.a = a;
         r.d = '0;
         for (int i = 0; i < COLS; i++)
            for (int p = 0; p < PL; p++)
               r.d[p*COLS + COLS-1-i] = bits_q[i][p];
         if (drop) exp_ovf++;
         else exp_q.push_back(r);
      end else begin
         exp_err++;
      end
      bits_q.delete();
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift(input logic [5:0] v);
      rgb = v;
      bclk = 1'b0;
      tick(2);
      bclk = 1'b1;
      bits_q.push_back(v);
      tick(2);
   endtask

   task automatic latch(input logic [3:0] a, input bit lat,
                        input bit late, input bit drop);
      bclk = 1'b0;
      addr = a;
      le = 1'b1;
      model_latch(a, drop);
      tick(2);
      if (lat) chk("latency_k1", RW'(row_if.row_valid), RW'(0));
      le = 1'b0;
      if (late) row_if.row_ready = 1'b1;
      tick(1);
      if (lat) chk("latency_k2", RW'(row_if.row_valid), RW'(1));
      if (late) row_if.row_ready = 1'b0;
      tick(3);
   endtask

   task automatic send_row(input logic [3:0] a, input int n,
                           input bit late, input bit drop);
      for (int i = 0; i < n; i++) shift(6'($urandom));
      latch(a, 1'b0, late, drop);
   endtask

   task automatic oe_pulse(input int n);
      oe_n = 1'b0;
      tick(n);
      oe_n = 1'b1;
      exp_oe++;
      tick(5);
   endtask

   initial begin
      logic [63:0]   pat;
      logic [RW-1:0] pat_row;
      int            n;
      int            len;
      row_if.row_ready = 1'b0;
      tick(3);
      n_reset = 1'b1;
      tick(2);

      // Build some state, then reset in the middle of a row.
      send_row(4'd9, COLS, 1'b0, 1'b0);
      chk("pre_reset_valid", RW'(row_if.row_valid), RW'(1));
      oe_pulse(10);
      chk("pre_reset_oe", RW'(oe_last), RW'(10));
      for (int i = 0; i < 30; i++) shift(6'($urandom));
      n_reset = 1'b0;
      exp_q.delete();
      bits_q.delete();
      tick(1);
      bclk = 1'b0;
      chk("rst_row_valid", RW'(row_if.row_valid), RW'(0));
      chk("rst_row_data", row_if.row_data, RW'(0));
      chk("rst_row_addr", RW'(row_if.row_addr), RW'(0));
      chk("rst_len_err", RW'(row_len_err), RW'(0));
      chk("rst_overflow", RW'(overflow), RW'(0));
      chk("rst_oe_valid", RW'(oe_valid), RW'(0));
      chk("rst_oe_cycles", RW'(oe_cycles), RW'(0));
      tick(2);
      n_reset = 1'b1;
      tick(2);
      send_row(4'd3, COLS-1, 1'b0, 1'b0);
      chk("post_rst_err", RW'(err_seen), RW'(exp_err));
      chk("post_rst_no_row", RW'(row_if.row_valid), RW'(0));

      // Full row with latency check.
      pat = 64'h8000_0000_0000_0001;
      for (int i = 0; i < COLS; i++)
         shift((i == 0 || i == COLS-1) ? 6'b000100 : 6'b000000);
      latch(4'd5, 1'b1, 1'b0, 1'b0);
      pat_row = RW'(pat) << (2 * COLS);
      chk("full_addr", RW'(row_if.row_addr), RW'(5));
      chk("full_data", row_if.row_data, pat_row);
      row_if.row_ready = 1'b1;
      tick(2);
      chk("full_drained", RW'(row_if.row_valid), RW'(0));

      // Length errors, then a good row.
      send_row(4'd3, COLS-1, 1'b0, 1'b0);
      send_row(4'd4, COLS+1, 1'b0, 1'b0);
      chk("len_err_cnt", RW'(err_seen), RW'(exp_err));
      send_row(4'd6, COLS, 1'b0, 1'b0);
      chk("len_good_row", RW'(exp_q.size()), RW'(0));

      // Random rows of length 63/64/65.
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(0, 3);
         len = (n == 0) ? COLS-1 : (n == 1) ? COLS+1 : COLS;
         send_row(4'($urandom), len, 1'b0, 1'b0);
      end
      chk("rand_err_cnt", RW'(err_seen), RW'(exp_err));
      chk("rand_rows_done", RW'(exp_q.size()), RW'(0));

      // 64th BCLK rise coincides with LE rise.
      for (int i = 0; i < COLS-1; i++) shift(6'($urandom));
      rgb = 6'($urandom);
      bclk = 1'b0;
      tick(2);
      bits_q.push_back(rgb);
      bclk = 1'b1;
      addr = 4'd7;
      le = 1'b1;
      model_latch(4'd7, 1'b0);
      tick(2);
      le = 1'b0;
      bclk = 1'b0;
      tick(4);
      chk("simul_no_err", RW'(err_seen), RW'(exp_err));
      chk("simul_row", RW'(exp_q.size()), RW'(0));

      // OE timing runs alongside row shifting.
      n = $urandom_range(20, 300);
      fork
         send_row(4'hA, COLS, 1'b0, 1'b0);
         begin
            tick(5);
            oe_pulse(n);
         end
      join
      chk("oe_concurrent", RW'(oe_last), RW'(n));
      chk("oe_conc_row", RW'(exp_q.size()), RW'(0));

      // Backpressure.
      row_if.row_ready = 1'b0;
      send_row(4'd1, COLS, 1'b0, 1'b0);
      chk("bp_hold_valid", RW'(row_if.row_valid), RW'(1));
      send_row(4'd2, COLS, 1'b0, 1'b1);
      chk("bp_overflow", RW'(ovf_seen), RW'(exp_ovf));
      chk("bp_addr_kept", RW'(row_if.row_addr), RW'(1));
      send_row(4'd2, COLS, 1'b1, 1'b0);
      chk("bp_swap_addr", RW'(row_if.row_addr), RW'(2));
      chk("bp_swap_valid", RW'(row_if.row_valid), RW'(1));
      chk("bp_no_ovf", RW'(ovf_seen), RW'(exp_ovf));
      row_if.row_ready = 1'b1;
      tick(3);

      // OE on-time and saturation.
      oe_pulse(100);
      chk("oe_100", RW'(oe_last), RW'(100));
      oe_pulse(70000);
      chk("oe_sat", RW'(oe_last), RW'(16'hFFFF));

      tick(5);
      chk("end_rows", RW'(exp_q.size()), RW'(0));
      chk("end_err", RW'(err_seen), RW'(exp_err));
      chk("end_ovf", RW'(ovf_seen), RW'(exp_ovf));
      chk("end_oe", RW'(oe_seen), RW'(exp_oe));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
